// File: rtl/rib_dmem_arb.sv
// Three-master round-robin arbiter (core data, debug, DMA) onto one req/ack data slave.
// Optional RIB_ARB_TIMEOUT_EN forces completion with TO_DATA and err_o after TIMEOUT_CYC unacked BUSY cycles.
module rib_dmem_arb #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] TO_DATA     = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,

  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_data_i,
  output logic [DATA_W-1:0] m2_data_o,
  output logic              m2_ack_o,

  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,

  output logic [2:0]        grant_o,
  output logic              busy_o,
  output logic              hold_flag_o,
  output logic              err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_q, last_d;
  logic [2:0]  req;
  logic        greq;
  logic        done;
  logic        to_hit;
  logic [2:0]  ack;
  logic [DATA_W-1:0] cpl_data;

  assign req = {m2_req_i, m1_req_i, m0_req_i};

  // Round-robin pick: search starts at the master after 'last'.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [2:0] last);
    logic [2:0] p;
    p = 3'b000;
    case (last)
      3'b001:  p = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
      3'b010:  p = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
      default: p = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    endcase
    return p;
  endfunction

  assign greq = (state_q == BUSY) && ((grant_q & req) != 3'b000);
  assign done = greq && (s_ack_i || to_hit);

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // A real slave ack in the same cycle wins over the forced completion.
  assign to_hit = greq && !s_ack_i && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (greq && !done) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  // Timeout disabled: constant-false expression keeps TIMEOUT_CYC referenced.
  assign to_hit = (TIMEOUT_CYC > 32'hFFFF_FFFE) && 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      last_q  <= 3'b100;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          grant_d = rr_pick(req, last_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!greq) begin
          grant_d = 3'b000;
          state_d = IDLE;
        end else if (done) begin
          // The just-served master is masked so it can only compete next cycle.
          last_d  = grant_q;
          grant_d = rr_pick(req & ~grant_q, grant_q);
          state_d = (grant_d != 3'b000) ? BUSY : IDLE;
        end
      end
      default: begin
        grant_d = 3'b000;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    if (state_q == BUSY) begin
      case (grant_q)
        3'b001: begin
          s_we_o   = m0_we_i;
          s_addr_o = m0_addr_i;
          s_data_o = m0_data_i;
        end
        3'b010: begin
          s_we_o   = m1_we_i;
          s_addr_o = m1_addr_i;
          s_data_o = m1_data_i;
        end
        3'b100: begin
          s_we_o   = m2_we_i;
          s_addr_o = m2_addr_i;
          s_data_o = m2_data_i;
        end
        default: begin
          s_we_o   = 1'b0;
          s_addr_o = '0;
          s_data_o = '0;
        end
      endcase
    end
  end

  assign s_req_o  = greq && !to_hit;
  assign ack      = done ? grant_q : 3'b000;
  assign cpl_data = to_hit ? TO_DATA : s_data_i;

  assign m0_ack_o  = ack[0];
  assign m1_ack_o  = ack[1];
  assign m2_ack_o  = ack[2];
  assign m0_data_o = ack[0] ? cpl_data : '0;
  assign m1_data_o = ack[1] ? cpl_data : '0;
  assign m2_data_o = ack[2] ? cpl_data : '0;

  assign grant_o     = grant_q;
  assign busy_o      = (state_q == BUSY);
  assign hold_flag_o = m0_req_i && !m0_ack_o;
  assign err_o       = to_hit;

endmodule

// File: tb/tb_rib_dmem_arb.sv
// Directed self-checking bench for rib_dmem_arb (TIMEOUT_CYC overridden to 4).
module tb_rib_dmem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m2_req = 0, m2_we = 0;
  logic [31:0] m0_addr = 0, m0_wd = 0, m1_addr = 0, m1_wd = 0, m2_addr = 0, m2_wd = 0;
  logic [31:0] m0_rd, m1_rd, m2_rd;
  logic        m0_ack, m1_ack, m2_ack;
  logic        s_req, s_we, s_ack = 0;
  logic [31:0] s_addr, s_wd, s_rd = 0;
  logic [2:0]  grant;
  logic        busy, hold, err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rib_dmem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4), .TO_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wd),
    .m0_data_o(m0_rd), .m0_ack_o(m0_ack),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wd),
    .m1_data_o(m1_rd), .m1_ack_o(m1_ack),
    .m2_req_i(m2_req), .m2_we_i(m2_we), .m2_addr_i(m2_addr), .m2_data_i(m2_wd),
    .m2_data_o(m2_rd), .m2_ack_o(m2_ack),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_wd),
    .s_data_i(s_rd), .s_ack_i(s_ack),
    .grant_o(grant), .busy_o(busy), .hold_flag_o(hold), .err_o(err)
  );

  // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    settle();
    chk("rst_grant", {29'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sreq", {31'd0, s_req}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);

    // Single read from m1, slave acks two cycles after s_req.
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 32'h1000_0004;
    settle();
    chk("rd_sreq_T", {31'd0, s_req}, 32'd0);
    tick(); settle();
    chk("rd_sreq_T1", {31'd0, s_req}, 32'd1);
    chk("rd_grant", {29'd0, grant}, 32'd2);
    chk("rd_addr", s_addr, 32'h1000_0004);
    tick(); settle();
    chk("rd_noack", {31'd0, m1_ack}, 32'd0);
    tick();
    s_ack = 1; s_rd = 32'h1234_5678;
    settle();
    chk("rd_ack", {31'd0, m1_ack}, 32'd1);
    chk("rd_data", m1_rd, 32'h1234_5678);
    chk("rd_other_ack", {30'd0, m2_ack, m0_ack}, 32'd0);
    tick();
    s_ack = 0; s_rd = 0; m1_req = 0;
    settle();
    chk("rd_idle", {31'd0, busy}, 32'd0);

    // Round robin after reset with all three holding requests.
    rst = 1; tick(); rst = 0;
    m0_req = 1; m1_req = 1; m2_req = 1;
    m0_addr = 32'hA0; m1_addr = 32'hA1; m2_addr = 32'hA2;
    tick(); settle();
    chk("rr_g0", {29'd0, grant}, 32'd1);
    tick(); s_ack = 1; settle();
    chk("rr_ack0", {29'd0, m2_ack, m1_ack, m0_ack}, 32'd1);
    chk("rr_sreq0", {31'd0, s_req}, 32'd1);
    tick(); s_ack = 0; settle();
    chk("rr_g1", {29'd0, grant}, 32'd2);
    chk("rr_sreq1", {31'd0, s_req}, 32'd1);
    tick(); s_ack = 1; settle();
    chk("rr_ack1", {29'd0, m2_ack, m1_ack, m0_ack}, 32'd2);
    tick(); s_ack = 0; settle();
    chk("rr_g2", {29'd0, grant}, 32'd4);
    chk("rr_addr2", s_addr, 32'hA2);
    tick(); s_ack = 1; settle();
    chk("rr_ack2", {29'd0, m2_ack, m1_ack, m0_ack}, 32'd4);
    tick(); s_ack = 0; settle();
    chk("rr_g3", {29'd0, grant}, 32'd1);
    m0_req = 0; m1_req = 0; m2_req = 0;
    settle();
    chk("rr_abort_sreq", {31'd0, s_req}, 32'd0);
    tick(); settle();
    chk("rr_idle", {31'd0, busy}, 32'd0);

    // Core stall while DMA write is in flight; m0 is served next.
    m2_req = 1; m2_we = 1; m2_wd = 32'h5555_AAAA; m2_addr = 32'h2000_0000;
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h3000_0000;
    settle();
    chk("st_grant", {29'd0, grant}, 32'd4);
    chk("st_hold0", {31'd0, hold}, 32'd1);
    chk("st_we", {31'd0, s_we}, 32'd1);
    chk("st_wdata", s_wd, 32'h5555_AAAA);
    tick(); s_ack = 1; settle();
    chk("st_m2ack", {31'd0, m2_ack}, 32'd1);
    chk("st_hold1", {31'd0, hold}, 32'd1);
    tick(); s_ack = 0; m2_req = 0; settle();
    chk("st_g0", {29'd0, grant}, 32'd1);
    chk("st_hold2", {31'd0, hold}, 32'd1);
    tick(); s_ack = 1; s_rd = 32'hCAFE_0001; settle();
    chk("st_m0ack", {31'd0, m0_ack}, 32'd1);
    chk("st_m0data", m0_rd, 32'hCAFE_0001);
    chk("st_hold3", {31'd0, hold}, 32'd0);
    tick(); s_ack = 0; s_rd = 0; m0_req = 0; settle();
    chk("st_idle", {31'd0, busy}, 32'd0);

    // Abort: m1 drops its request before any ack.
    m1_req = 1; m1_we = 0;
    tick(); settle();
    chk("ab_grant", {29'd0, grant}, 32'd2);
    tick(); m1_req = 0; s_ack = 1; settle();
    chk("ab_sreq", {31'd0, s_req}, 32'd0);
    chk("ab_noack", {31'd0, m1_ack}, 32'd0);
    tick(); settle();
    chk("ab_late_ack", {31'd0, m1_ack}, 32'd0);
    chk("ab_idle", {31'd0, busy}, 32'd0);
    s_ack = 0;

    // Reset mid-BUSY; after reset m0 wins over m2.
    m2_req = 1;
    tick(); settle();
    chk("rb_busy", {29'd0, grant}, 32'd4);
    rst = 1;
    tick(); settle();
    chk("rb_grant", {29'd0, grant}, 32'd0);
    chk("rb_busyo", {31'd0, busy}, 32'd0);
    rst = 0; m0_req = 1;
    tick(); settle();
    chk("rb_m0wins", {29'd0, grant}, 32'd1);
    m0_req = 0; m2_req = 0;
    tick(); settle();

    // m0 read with a slave that never acks.
    m0_req = 1; m0_we = 0;
    tick();
`ifdef RIB_ARB_TIMEOUT_EN
    settle();
    chk("to_wait1", {31'd0, m0_ack}, 32'd0);
    tick(); tick(); tick(); settle();
    chk("to_ack", {31'd0, m0_ack}, 32'd1);
    chk("to_data", m0_rd, 32'hDEAD_BEEF);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_sreq", {31'd0, s_req}, 32'd0);
    tick(); m0_req = 0; settle();
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_err_off", {31'd0, err}, 32'd0);
`else
    begin
      logic held_ok;
      held_ok = 1'b1;
      for (int i = 0; i < 110; i++) begin
        settle();
        if (!(busy === 1'b1 && err === 1'b0)) held_ok = 1'b0;
        tick();
      end
      chk("nto_hold", {31'd0, held_ok}, 32'd1);
    end
    m0_req = 0;
    tick(); settle();
    chk("nto_idle", {31'd0, busy}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
